// File: rtl/fifo_pkt_framer_if.sv
// Stream and FIFO-read signals between the packet framer and its FIFO/sink.
// A word moves on the stream when out_valid && out_ready at posedge clk. Once
// out_valid rises, it stays high and out_data stays stable until that transfer.
interface fifo_pkt_framer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_read;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  out_ready,
        output fifo_read,
        output out_data,
        output out_valid,
        output out_last
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output out_ready,
        input  fifo_read,
        input  out_data,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/fifo_pkt_framer.sv
// Reads the show-ahead port of a FIFO and emits fixed-length frames on a stream:
// a header word, PKT_LEN payload words, then a checksum word.
module fifo_pkt_framer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PKT_LEN = 8,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rstn,
    fifo_pkt_framer_if.master        bus,
    output logic                     busy,
    output logic [15:0]              pkt_count,
    output logic [1:0]               dbg_state
);
    localparam int unsigned      CNT_W    = $clog2(PKT_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [7:0]        seq_q,       seq_d;
    logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;
    logic [DATA_W-1:0] csum_q,      csum_d;
    logic [15:0]       pkt_count_q, pkt_count_d;

    logic              xfer;
    logic [DATA_W-1:0] header_word;

    always_comb begin
        header_word       = '0;
        header_word[15:0] = {SYNC, seq_q};
    end

    // Stream outputs are gated during reset so the abandoned frame neither
    // offers a word nor pops the FIFO in the reset cycle.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.fifo_read = 1'b0;
        if (rstn) begin
            case (state_q)
                HEADER: begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = header_word;
                end
                PAYLOAD: begin
                    bus.out_valid = !bus.fifo_empty;
                    bus.out_data  = bus.fifo_dout;
                    bus.fifo_read = bus.out_ready && !bus.fifo_empty;
                end
                CHECKSUM: begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = csum_q;
                    bus.out_last  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign xfer = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        word_cnt_d  = word_cnt_q;
        csum_d      = csum_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) state_d = HEADER;
            end
            HEADER: begin
                if (xfer) begin
                    csum_d     = '0;
                    word_cnt_d = '0;
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    csum_d     = csum_q + bus.fifo_dout;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q == LAST_IDX) state_d = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (xfer) begin
                    seq_d       = seq_q + 8'd1;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            word_cnt_q  <= word_cnt_d;
            csum_q      <= csum_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer: behavioural FIFO, stream scoreboard, directed
// packet table plus hand-written stall, back-pressure, wrap and reset sequences.
module tb_fifo_pkt_framer;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PKT_LEN = 4;

    typedef struct {
        logic [15:0] pay [4];
        logic [15:0] csum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        busy;
    logic [15:0] pkt_count;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fifo_pkt_framer_if #(.DATA_W(DATA_W)) bus ();

    fifo_pkt_framer #(
        .DATA_W (DATA_W),
        .PKT_LEN(PKT_LEN),
        .SYNC   (8'hA5)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.master),
        .busy     (busy),
        .pkt_count(pkt_count),
        .dbg_state(dbg_state)
    );

    // Behavioural show-ahead FIFO.
    logic [15:0] fifo_mem [64];
    logic [15:0] wr_ptr = '0;
    logic [15:0] rd_ptr = '0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_dout  = fifo_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (bus.fifo_read && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 16'd1;
    end

    // Sink ready: either a steady level or a per-cycle toggle.
    logic rdy    = 1'b1;
    logic tog_en = 1'b0;
    logic tog_r  = 1'b1;
    assign bus.out_ready = tog_en ? tog_r : rdy;

    always @(posedge clk) begin
        #1;
        if (tog_en) tog_r = ~tog_r;
    end

    // Scoreboard state.
    logic [16:0] exp_q [$];
    logic [7:0]  model_seq = '0;
    logic [15:0] exp_pkt   = '0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cyc       = 0;
    int          pops      = 0;
    int          xfer_n    = 0;
    int          xcyc [4096];
    logic        mon_en    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sampled on the falling edge; a valid&&ready seen here transfers at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.fifo_read) pops++;
            if (bus.fifo_empty) check("no_pop_on_empty", {31'd0, bus.fifo_read}, 32'd0);
            if (!bus.out_ready) check("no_pop_when_stalled", {31'd0, bus.fifo_read}, 32'd0);
            if (prev_stall) begin
                check("stall_valid_held", {31'd0, bus.out_valid}, 32'd1);
                check("stall_data_held", {16'd0, bus.out_data}, {16'd0, prev_data});
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (xfer_n < 4096) xcyc[xfer_n] = cyc;
                xfer_n++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got last=%0b data=%0h with nothing expected",
                             bus.out_last, bus.out_data);
                end else begin
                    check("stream_word", {15'd0, bus.out_last, bus.out_data}, {15'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic expect_pkt(input logic [15:0] pay [4], input logic [15:0] csum);
        exp_q.push_back({1'b0, 8'hA5, model_seq});
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, pay[k]});
        exp_q.push_back({1'b1, csum});
        model_seq = model_seq + 8'd1;
        exp_pkt   = exp_pkt + 16'd1;
    endtask

    task automatic wait_drain(input int budget);
        int b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            @(negedge clk);
            #1;
            b--;
        end
        check("drain_in_time", exp_q.size(), 32'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int b = budget;
        while (xfer_n < n && b > 0) begin
            @(negedge clk);
            #1;
            b--;
        end
        check("xfer_in_time", {31'd0, (xfer_n >= n)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [4];
        logic [15:0] pay  [4];
        logic [15:0] sum;
        int          base;
        int          pops0;

        vecs[0] = '{pay: '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, csum: 16'h000A};
        vecs[1] = '{pay: '{16'hFFFF, 16'h0002, 16'h0000, 16'h0001}, csum: 16'h0002};
        vecs[2] = '{pay: '{16'h1234, 16'h1111, 16'h0F0F, 16'h8000}, csum: 16'hB254};
        vecs[3] = '{pay: '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, csum: 16'h0000};

        // Reset state.
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        tick();
        rstn   = 1'b1;
        mon_en = 1'b1;
        tick();
        check("idle_empty_stays_idle", {30'd0, dbg_state}, 32'd0);

        // Table: single packets with hand-computed checksums.
        for (int i = 0; i < 4; i++) begin
            pops0 = pops;
            expect_pkt(vecs[i].pay, vecs[i].csum);
            for (int k = 0; k < 4; k++) push_word(vecs[i].pay[k]);
            wait_drain(100);
            check("vec_pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkt});
            check("vec_pops", pops - pops0, 32'd4);
            check("vec_idle_after", {31'd0, busy}, 32'd0);
        end

        // Back-to-back: eight words preloaded, one bubble between checksum and next header.
        base = xfer_n;
        pay = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        expect_pkt(pay, 16'h00A0);
        for (int k = 0; k < 4; k++) push_word(pay[k]);
        pay = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        expect_pkt(pay, 16'h0A00);
        for (int k = 0; k < 4; k++) push_word(pay[k]);
        wait_drain(200);
        check("b2b_gap", xcyc[base + 6] - xcyc[base + 5], 32'd2);

        // Back-pressure: ready toggles every cycle.
        pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        expect_pkt(pay, 16'h000A);
        tog_en = 1'b1;
        for (int k = 0; k < 4; k++) push_word(pay[k]);
        wait_drain(200);
        tog_en = 1'b0;
        check("toggle_pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // FIFO runs dry after two payload words for ten cycles.
        base = xfer_n;
        pay = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        expect_pkt(pay, 16'h00AA);
        push_word(pay[0]);
        push_word(pay[1]);
        wait_xfers(base + 3, 50);
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("dry_valid", {31'd0, bus.out_valid}, 32'd0);
            check("dry_pop", {31'd0, bus.fifo_read}, 32'd0);
        end
        tick();
        push_word(pay[2]);
        push_word(pay[3]);
        wait_drain(100);
        check("dry_pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // 256 packets so the 8-bit sequence wraps back through A500.
        for (int p = 0; p < 256; p++) begin
            sum = '0;
            for (int k = 0; k < 4; k++) begin
                pay[k] = 16'($urandom_range(0, 65535));
                sum    = sum + pay[k];
            end
            expect_pkt(pay, sum);
            for (int k = 0; k < 4; k++) push_word(pay[k]);
            wait_drain(100);
        end
        check("wrap_pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // Reset during payload after two words.
        base = xfer_n;
        pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        expect_pkt(pay, 16'h000A);
        for (int k = 0; k < 4; k++) push_word(pay[k]);
        wait_xfers(base + 3, 50);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_no_pop", {31'd0, bus.fifo_read}, 32'd0);
        check("rst_mid_no_last", {31'd0, bus.out_last}, 32'd0);
        exp_q.delete();
        model_seq = '0;
        exp_pkt   = '0;
        tick();
        rstn = 1'b1;
        check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
        check("rst_mid_pkt_count", {16'd0, pkt_count}, 32'd0);
        pay = '{16'h0003, 16'h0004, 16'h0005, 16'h0006};
        expect_pkt(pay, 16'h0012);
        push_word(16'h0005);
        push_word(16'h0006);
        wait_drain(100);
        check("post_rst_pkt_count", {16'd0, pkt_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
